// File: rtl/jstk_spi_responder_pkg.sv
// Shared types and constants for the PmodJSTK SPI responder.
// Holds the FSM state enum, frame constants and the frame packing helper.
package jstk_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} jstk_state_e;

    localparam int         JSTK_FRAME_BYTES = 5;
    localparam logic [5:0] JSTK_CMD_HDR     = 6'b100000;

    localparam int B_XLO = 0;
    localparam int B_XHI = 1;
    localparam int B_YLO = 2;
    localparam int B_YHI = 3;
    localparam int B_BTN = 4;

    // Byte B_XLO lands in the MSBs so it is the first byte shifted out.
    function automatic logic [JSTK_FRAME_BYTES*8-1:0] jstk_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] b
    );
        logic [0:JSTK_FRAME_BYTES-1][7:0] f;
        f[B_XLO] = x[7:0];
        f[B_XHI] = {6'b0, x[9:8]};
        f[B_YLO] = y[7:0];
        f[B_YHI] = {6'b0, y[9:8]};
        f[B_BTN] = {5'b0, b};
        return f;
    endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI bus between a joystick master and the responder.
// The master drives ss_n/sclk/mosi; the slave drives miso.
interface jstk_spi_responder_if;
    logic ss_n;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output ss_n, output sclk, output mosi, input miso);
    modport slave  (input ss_n, input sclk, input mosi, output miso);
endinterface

// File: rtl/jstk_spi_responder_sync.sv
// Pin synchronizer with registered rise/fall detect taken from the last two flops.
// RST_VAL is the idle level of the pin so reset release creates no false edge.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_rise <= r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
            r_fall <= ~r_sync[SYNC_STAGES-2] & r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating a PmodJSTK: answers 5-byte frames with X/Y/buttons, latches LED command.
// Optional macro JSTK_RESP_STATS_EN adds frame_cnt/abort_cnt statistics outputs.
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BYTES   = JSTK_FRAME_BYTES,
    parameter int POS_W       = 10
) (
    input  logic                 clk,
    input  logic                 clr_n,
    jstk_spi_responder_if.slave  spi,
    input  logic [POS_W-1:0]     pos_x,
    input  logic [POS_W-1:0]     pos_y,
    input  logic [2:0]           btn,
    output logic [1:0]           led,
    output logic                 cmd_valid,
    output logic                 frame_done,
    output logic                 busy
`ifdef JSTK_RESP_STATS_EN
    ,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          abort_cnt
`endif
);

    localparam int         TX_W      = JSTK_FRAME_BYTES * 8;
    localparam logic [7:0] NB        = 8'(NUM_BYTES);
    localparam logic [7:0] LAST_BYTE = 8'(NUM_BYTES - 1);

    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    jstk_state_e r_state, w_state_nxt;
    logic [TX_W-1:0] r_tx;
    logic [7:0]      r_rx;
    logic [7:0]      w_rx_nxt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_byte_cnt;
    logic [1:0]      r_led;
    logic            r_cmd_valid;
    logic            r_frame_done;
    logic            r_busy;
`ifdef JSTK_RESP_STATS_EN
    logic [15:0]     r_frame_cnt;
    logic [15:0]     r_abort_cnt;
`endif

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .clr_n(clr_n), .i_pin(spi.ss_n),
        .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .clr_n(clr_n), .i_pin(spi.sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .clr_n(clr_n), .i_pin(spi.mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_ss_level, w_sclk_level, w_mosi_rise, w_mosi_fall};
    assign w_rx_nxt = {r_rx[6:0], w_mosi};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // ss_n edges take priority over any sclk edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_state_nxt = SHIFT;
            SHIFT: begin
                if (w_ss_rise)
                    w_state_nxt = IDLE;
                else if (w_sclk_rise && r_bit_cnt == 3'd7 && r_byte_cnt == LAST_BYTE)
                    w_state_nxt = OVERRUN;
            end
            OVERRUN: if (w_ss_rise) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_tx         <= '0;
            r_rx         <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_led        <= 2'b00;
            r_cmd_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
`ifdef JSTK_RESP_STATS_EN
            r_frame_cnt  <= '0;
            r_abort_cnt  <= '0;
`endif
        end else begin
            r_cmd_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_ss_fall) begin
                    r_tx       <= jstk_frame(pos_x[9:0], pos_y[9:0], btn);
                    r_rx       <= '0;
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_busy     <= 1'b1;
                end
            end else if (w_ss_rise) begin
                r_busy <= 1'b0;
                if (r_bit_cnt == 3'd0 && r_byte_cnt >= NB) begin
                    r_frame_done <= 1'b1;
`ifdef JSTK_RESP_STATS_EN
                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                end else begin
                    r_abort_cnt  <= r_abort_cnt + 16'd1;
`endif
                end
            end else if (w_sclk_rise) begin
                r_rx      <= w_rx_nxt;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    // Saturate so long overrun frames still read as complete.
                    if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
                    if (r_byte_cnt == 8'd0 && w_rx_nxt[7:2] == JSTK_CMD_HDR) begin
                        r_led       <= w_rx_nxt[1:0];
                        r_cmd_valid <= 1'b1;
                    end
                end
            end else if (w_sclk_fall && r_state == SHIFT) begin
                r_tx <= {r_tx[TX_W-2:0], 1'b0};
            end
        end
    end

    assign spi.miso   = (r_state == SHIFT) & r_tx[TX_W-1];
    assign led        = r_led;
    assign cmd_valid  = r_cmd_valid;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
`ifdef JSTK_RESP_STATS_EN
    assign frame_cnt  = r_frame_cnt;
    assign abort_cnt  = r_abort_cnt;
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: table of full frames plus hand-written corner sequences.
module tb_jstk_spi_responder;

    typedef struct {
        int          nbits;
        logic [7:0]  cmd;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        logic [39:0] frame;
        logic [1:0]  exp_led;
        int          exp_cv;
        int          exp_fd;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic [9:0] pos_x = '0;
    logic [9:0] pos_y = '0;
    logic [2:0] btn = '0;
    logic [1:0] led;
    logic cmd_valid, frame_done, busy;
`ifdef JSTK_RESP_STATS_EN
    logic [15:0] frame_cnt, abort_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cv_cnt = 0;
    int fd_cnt = 0;

    jstk_spi_responder_if spi_if ();

    jstk_spi_responder dut (
        .clk(clk), .clr_n(clr_n), .spi(spi_if),
        .pos_x(pos_x), .pos_y(pos_y), .btn(btn),
        .led(led), .cmd_valid(cmd_valid), .frame_done(frame_done), .busy(busy)
`ifdef JSTK_RESP_STATS_EN
        , .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid)  cv_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One SPI frame, mode 0, SCLK = clk/16. Optionally changes pos_x or pulses reset at a bit index.
    task automatic spi_frame(input int nbits, input logic [7:0] cmd, input int chg_bit,
                             input logic [9:0] chg_x, input int rst_bit,
                             output logic [63:0] rx, output logic busy_mid);
        rx = '0;
        busy_mid = 1'b0;
        @(negedge clk);
        spi_if.ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                clr_n = 1'b0;
                spi_if.ss_n = 1'b1;
                spi_if.sclk = 1'b0;
                repeat (2) @(negedge clk);
                chk("rst_mid_miso", 64'(spi_if.miso), 64'd0);
                chk("rst_mid_busy", 64'(busy), 64'd0);
                chk("rst_mid_led", 64'(led), 64'd0);
                clr_n = 1'b1;
                repeat (8) @(negedge clk);
                return;
            end
            if (i == chg_bit) pos_x = chg_x;
            spi_if.mosi = (i < 8) ? cmd[7-i] : 1'b0;
            repeat (8) @(negedge clk);
            rx = {rx[62:0], spi_if.miso};
            if (i == 0) busy_mid = busy;
            spi_if.sclk = 1'b1;
            repeat (8) @(negedge clk);
            spi_if.sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        spi_if.ss_n = 1'b1;
        spi_if.mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run_vec(input string nm, input vec_t v, input int chg_bit, input logic [9:0] chg_x);
        logic [63:0] rx;
        logic [63:0] e;
        logic        bm;
        int          cv0, fd0;
        pos_x = v.x;
        pos_y = v.y;
        btn   = v.btn;
        cv0 = cv_cnt;
        fd0 = fd_cnt;
        spi_frame(v.nbits, v.cmd, chg_bit, chg_x, -1, rx, bm);
        e = '0;
        for (int i = 0; i < v.nbits; i++) e = {e[62:0], (i < 40) ? v.frame[39-i] : 1'b0};
        chk($sformatf("%s_miso", nm), rx, e);
        chk($sformatf("%s_led", nm), 64'(led), 64'(v.exp_led));
        chk($sformatf("%s_cmd_valid", nm), 64'(cv_cnt - cv0), 64'(v.exp_cv));
        chk($sformatf("%s_frame_done", nm), 64'(fd_cnt - fd0), 64'(v.exp_fd));
        chk($sformatf("%s_busy_mid", nm), 64'(bm), 64'd1);
        chk($sformatf("%s_busy_end", nm), 64'(busy), 64'd0);
    endtask

    vec_t tbl[6];
    vec_t t;
    logic [63:0] rx6;
    logic        bm6;

    initial begin
        tbl[0] = '{40, 8'h83, 10'h2A5, 10'h17F, 3'b101, 40'hA5_02_7F_01_05, 2'b11, 1, 1};
        tbl[1] = '{40, 8'h40, 10'h3C0, 10'h255, 3'b010, 40'hC0_03_55_02_02, 2'b11, 0, 1};
        tbl[2] = '{40, 8'h81, 10'h000, 10'h3FF, 3'b111, 40'h00_00_FF_03_07, 2'b01, 1, 1};
        tbl[3] = '{40, 8'h80, 10'h155, 10'h0AA, 3'b000, 40'h55_01_AA_00_00, 2'b00, 1, 1};
        tbl[4] = '{40, 8'h82, 10'h001, 10'h002, 3'b000, 40'h01_00_02_00_00, 2'b10, 1, 1};
        tbl[5] = '{40, 8'h87, 10'h2A5, 10'h17F, 3'b101, 40'hA5_02_7F_01_05, 2'b10, 0, 1};

        spi_if.ss_n = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_miso", 64'(spi_if.miso), 64'd0);
        chk("reset_led", 64'(led), 64'd0);
        chk("reset_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("reset_frame_done", 64'(frame_done), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        clr_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i], -1, 10'h0);

        // Position change during byte 2 must not disturb the frame in flight.
        t = '{40, 8'h00, 10'h2A5, 10'h17F, 3'b101, 40'hA5_02_7F_01_05, 2'b10, 0, 1};
        run_vec("t2_snap", t, 18, 10'h001);
        t = '{40, 8'h00, 10'h001, 10'h17F, 3'b101, 40'h01_00_7F_01_05, 2'b10, 0, 1};
        run_vec("t2_next", t, -1, 10'h0);

        // Abort after 13 bits.
        t = '{13, 8'h00, 10'h2A5, 10'h17F, 3'b101, 40'hA5_02_7F_01_05, 2'b10, 0, 0};
        run_vec("t3_abort", t, -1, 10'h0);
`ifdef JSTK_RESP_STATS_EN
        chk("t3_abort_cnt", 64'(abort_cnt), 64'd1);
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd8);
`endif
        t = '{40, 8'h00, 10'h0F0, 10'h30F, 3'b011, 40'hF0_00_0F_03_03, 2'b10, 0, 1};
        run_vec("t3_after", t, -1, 10'h0);

        // Seven-byte frame: trailing bytes read zero, still a clean end.
        t = '{56, 8'h83, 10'h2A5, 10'h17F, 3'b101, 40'hA5_02_7F_01_05, 2'b11, 1, 1};
        run_vec("t4_long", t, -1, 10'h0);

        // Reset in the middle of byte 3.
        pos_x = 10'h2A5; pos_y = 10'h17F; btn = 3'b101;
        spi_frame(40, 8'h83, -1, 10'h0, 28, rx6, bm6);
        chk("t6_led_after", 64'(led), 64'd0);
        chk("t6_busy_after", 64'(busy), 64'd0);
        chk("t6_miso_after", 64'(spi_if.miso), 64'd0);
`ifdef JSTK_RESP_STATS_EN
        chk("t6_abort_cnt", 64'(abort_cnt), 64'd0);
`endif
        t = '{40, 8'h81, 10'h2A5, 10'h17F, 3'b101, 40'hA5_02_7F_01_05, 2'b01, 1, 1};
        run_vec("t6_next", t, -1, 10'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
